// File: rtl/pingpong_buffer_ctrl.sv
// pingpong_buffer_ctrl: two-bank ping-pong ownership, address generation and handshakes
// between a pixel writer and a stride-2 conv reader, with frame and drop accounting.
module pingpong_buffer_ctrl #(
  parameter int IMG_WORDS = 162,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en,
  output logic              rd_avail,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic [7:0]        frames_in,
  output logic [7:0]        frames_out,
  output logic [7:0]        drop_cnt,
  output logic              overflow
);
  typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_WORDS - 1);
  bank_state_t state [2];
  logic wb, rb, rd_fire;
  assign wr_bank  = wb;
  assign rd_bank  = rb;
  assign wr_ready = (state[wb] == FREE) || (state[wb] == FILLING);
  assign wr_en    = wr_valid && wr_ready;
  assign rd_avail = (state[rb] == FULL) || (state[rb] == DRAINING);
  assign rd_last  = rd_avail && (rd_addr == LAST);
  assign rd_fire  = rd_en && rd_avail;
  // wr_ready and rd_avail are mutually exclusive on a shared bank, so the two
  // state updates below never target the same entry in one cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state[0]   <= FREE;
      state[1]   <= FREE;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      frames_in  <= '0;
      frames_out <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        state[wb] <= (wr_addr == LAST) ? FULL : FILLING;
        wr_addr   <= (wr_addr == LAST) ? '0 : wr_addr + ADDR_W'(1);
        wb        <= wb ^ (wr_addr == LAST);
        frames_in <= frames_in + 8'((wr_addr == LAST));
      end
      if (wr_valid && !wr_ready) begin
        drop_cnt <= drop_cnt + 8'((drop_cnt != 8'hFF));
        overflow <= 1'b1;
      end
      if (rd_fire) begin
        state[rb]  <= rd_last ? FREE : DRAINING;
        rd_addr    <= rd_last ? '0 : rd_addr + ADDR_W'(1);
        rb         <= rb ^ rd_last;
        frames_out <= frames_out + 8'(rd_last);
      end
    end
endmodule

// File: tb/tb_pingpong_buffer_ctrl.sv
// tb_pingpong_buffer_ctrl: directed and randomized checks of the ping-pong controller
// against a word-count model (total words in/out determine banks, addresses and flags).
module tb_pingpong_buffer_ctrl;
  localparam int IMG = 162;
  logic clk = 0, reset = 1, wr_valid = 0, rd_en = 0;
  logic wr_ready, wr_en, wr_bank, rd_avail, rd_bank, rd_last, overflow;
  logic [7:0] wr_addr, rd_addr, frames_in, frames_out, drop_cnt;
  int checks = 0, errors = 0;
  int tin = 0, tout = 0, drops = 0;
  bit ovf = 0;

  pingpong_buffer_ctrl #(.IMG_WORDS(IMG), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_en(rd_en), .rd_avail(rd_avail),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_last(rd_last), .frames_in(frames_in),
    .frames_out(frames_out), .drop_cnt(drop_cnt), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic logic [46:0] exp_vec();
    int ci, co;
    logic rdy, av;
    logic [7:0] wa, ra, dc;
    ci = tin / IMG; co = tout / IMG;
    rdy = (ci - co) < 2; av = ci > co;
    wa = 8'(tin % IMG); ra = 8'(tout % IMG);
    dc = drops > 255 ? 8'd255 : 8'(drops);
    return {rdy, wr_valid & rdy, 1'(ci % 2), wa, av, 1'(co % 2), ra, av && (ra == 8'(IMG - 1)),
            8'(ci % 256), 8'(co % 256), dc, ovf};
  endfunction

  function automatic logic [46:0] dut_vec();
    return {wr_ready, wr_en, wr_bank, wr_addr, rd_avail, rd_bank, rd_addr, rd_last,
            frames_in, frames_out, drop_cnt, overflow};
  endfunction

  task automatic clear_model();
    tin = 0; tout = 0; drops = 0; ovf = 0;
  endtask

  task automatic set_in(input logic wv, input logic re);
    wr_valid = wv; rd_en = re;
    @(negedge clk);
  endtask

  task automatic adv();
    int ci, co;
    bit aw, ar;
    ci = tin / IMG; co = tout / IMG;
    aw = wr_valid && (ci - co) < 2;
    ar = rd_en && ci > co;
    if (wr_valid && !aw) begin drops++; ovf = 1; end
    @(posedge clk);
    tin += int'(aw); tout += int'(ar);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_valid = 0; rd_en = 0; reset = 0; clear_model();
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 reset = 0; clear_model();
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    checks++; if (rd_avail !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd got %b%b exp 00", rd_avail, rd_last); end
    checks++; if ({wr_addr, rd_addr, frames_in, frames_out, drop_cnt, overflow} !== 41'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", {wr_addr, rd_addr, frames_in, frames_out, drop_cnt, overflow}); end
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < IMG; i++) begin
      set_in(1, 0);
      checks++; if ({wr_en, wr_bank, wr_addr} !== {1'b1, 1'b0, i[7:0]}) begin errors++; $display("FAIL fill_wr i=%0d got en=%b bank=%b addr=%0d exp 1 0 %0d", i, wr_en, wr_bank, wr_addr, i); end
      adv();
    end
    set_in(0, 0);
    checks++; if ({rd_avail, rd_bank, wr_bank, frames_in} !== {3'b101, 8'd1}) begin errors++; $display("FAIL fill_done got avail=%b rb=%b wb=%b fin=%0d exp 1 0 1 1", rd_avail, rd_bank, wr_bank, frames_in); end
    adv();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < IMG; i++) begin set_in(1, 0); adv(); end
    set_in(1, 0);
    checks++; if (wr_ready !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL ovf_ready got rdy=%b en=%b exp 0 0", wr_ready, wr_en); end
    adv();
    for (int i = 0; i < 4; i++) begin set_in(1, 0); adv(); end
    set_in(0, 0);
    checks++; if ({drop_cnt, overflow, frames_in} !== {8'd5, 1'b1, 8'd2}) begin errors++; $display("FAIL ovf_counts got drop=%0d ovf=%b fin=%0d exp 5 1 2", drop_cnt, overflow, frames_in); end
    adv();
  endtask

  task automatic test_drain();
    for (int i = 0; i < IMG; i++) begin
      set_in(0, 1);
      checks++; if ({rd_bank, rd_addr, rd_last} !== {1'b0, i[7:0], i == IMG - 1}) begin errors++; $display("FAIL drain_rd i=%0d got bank=%b addr=%0d last=%b", i, rd_bank, rd_addr, rd_last); end
      adv();
    end
    set_in(0, 0);
    checks++; if ({wr_ready, wr_bank, rd_bank, rd_avail, frames_out} !== {4'b1011, 8'd1}) begin errors++; $display("FAIL drain_done got rdy=%b wb=%b rb=%b av=%b fout=%0d exp 1 0 1 1 1", wr_ready, wr_bank, rd_bank, rd_avail, frames_out); end
    adv();
  endtask

  task automatic test_release_drop();
    for (int i = 0; i < IMG; i++) begin set_in(1, 0); adv(); end
    for (int i = 0; i < IMG; i++) begin
      set_in(1, 1);
      if (i == IMG - 1) begin
        checks++; if ({rd_last, wr_en} !== 2'b10) begin errors++; $display("FAIL rel_last got last=%b wr_en=%b exp 1 0", rd_last, wr_en); end
      end
      adv();
    end
    set_in(1, 0);
    checks++; if (drop_cnt !== 8'd167) begin errors++; $display("FAIL rel_drop got %0d exp 167", drop_cnt); end
    checks++; if ({wr_en, wr_bank, wr_addr} !== {2'b11, 8'd0}) begin errors++; $display("FAIL rel_write got en=%b bank=%b addr=%0d exp 1 1 0", wr_en, wr_bank, wr_addr); end
    adv();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 2 * IMG + 300; i++) begin set_in(1, 0); adv(); end
    set_in(0, 0);
    checks++; if ({drop_cnt, overflow} !== {8'd255, 1'b1}) begin errors++; $display("FAIL sat_drop got %0d ovf=%b exp 255 1", drop_cnt, overflow); end
    adv();
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 0; i < 4 * IMG; i++) begin set_in(1, 1); adv(); end
    set_in(0, 0);
    checks++; if ({drop_cnt, frames_in, frames_out} !== {8'd0, 8'd4, 8'd3}) begin errors++; $display("FAIL conc_counts got drop=%0d fin=%0d fout=%0d exp 0 4 3", drop_cnt, frames_in, frames_out); end
    adv();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 80; i++) begin set_in(1, 0); adv(); end
    set_in(0, 0);
    checks++; if (wr_addr !== 8'd80) begin errors++; $display("FAIL ares_pre got %0d exp 80", wr_addr); end
    reset = 0; clear_model();
    #1;
    checks++; if ({wr_ready, wr_en, rd_avail, rd_last, wr_addr, wr_bank} !== {4'b1000, 8'd0, 1'b0}) begin errors++; $display("FAIL ares_out got rdy=%b en=%b av=%b last=%b addr=%0d bank=%b", wr_ready, wr_en, rd_avail, rd_last, wr_addr, wr_bank); end
    #2 reset = 1;
    @(posedge clk); #1;
    set_in(1, 0);
    checks++; if ({wr_en, wr_bank, wr_addr} !== {2'b10, 8'd0}) begin errors++; $display("FAIL ares_first got en=%b bank=%b addr=%0d exp 1 0 0", wr_en, wr_bank, wr_addr); end
    adv();
  endtask

  task automatic test_random();
    int pw, pr;
    logic [46:0] e;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      pw = $urandom_range(20, 100); pr = $urandom_range(20, 100);
      for (int i = 0; i < 500; i++) begin
        set_in($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
        e = exp_vec();
        checks++; if (dut_vec() !== e) begin errors++; $display("FAIL rand_vec seg=%0d i=%0d got %h exp %h", s, i, dut_vec(), e); end
        adv();
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_release_drop();
    test_saturate();
    test_concurrent();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
